cpu64_l1_tl_ul_bridge: RTL
==========================

Name: cpu64_l1_tl_ul_bridge

Overview:
- Downstream of cpu64_l1_dcache. Converts the cache's memory-side req/gnt/rvalid port into a TileLink-UL master: A channel out, D channel in.
- Up to NUM_OUTSTANDING requests in flight; responses are returned to the cache in issue order.
- Sits between the L1 and the TL-UL crossbar / L2 port.

Parameters:
- AW, 64, address width on both sides.
- NUM_OUTSTANDING, 4, max in-flight TL transactions (power of two, ≥2).
- SRC_W, 2, a_source/d_source width; must equal log2(NUM_OUTSTANDING).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_i  in  1  cache memory request
- we_i  in  1  1 = write
- be_i  in  8  byte enables (writes)
- addr_i  in  AW  8-byte-aligned address
- wdata_i  in  64  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  read data valid (single-cycle pulse)
- rdata_o  out  64  read data
- a_valid_o  out  1  TL A valid
- a_ready_i  in  1  TL A ready
- a_opcode_o  out  3  0 = PutFullData, 1 = PutPartialData, 4 = Get
- a_size_o  out  3  always 3
- a_source_o  out  SRC_W  transaction tag
- a_address_o  out  AW
- a_mask_o  out  8
- a_data_o  out  64
- d_valid_i  in  1
- d_ready_o  out  1  tied 1
- d_opcode_i  in  3  0 = AccessAck, 1 = AccessAckData
- d_source_i  in  SRC_W
- d_denied_i  in  1
- d_corrupt_i  in  1
- d_data_i  in  64
- err_o  out  1  sticky protocol/bus error
- idle_o  out  1  no transaction held or in flight

Behaviour:
- Reset (rst_n = 0 at clk edge):
  - a_valid_o = 0, rvalid_o = 0, err_o = 0, idle_o = 1.
  - rdata_o = 0, a_* payload = 0.
  - Tracker empty; source counter = 0.
- Accept:
  - gnt_o = req_i && !a_hold && !trk_full. Combinational from registered state only; no dependency on a_ready_i.
  - On gnt, the A holding register loads:
    - opcode = Get if !we_i; PutFullData if we_i && be_i == 8'hFF; else PutPartialData.
    - mask = 8'hFF for Get, otherwise be_i.
    - data = wdata_i; address = addr_i; source = src_cnt.
  - On gnt, src_cnt increments mod NUM_OUTSTANDING, and the tracker pushes {source, is_read}.
- A channel:
  - a_valid_o rises the cycle after gnt.
  - Payload is held stable until a_valid_o && a_ready_i. a_valid_o then drops the next cycle unless a new gnt occurred in the fire cycle.
  - gnt is blocked while a_hold = 1, so the A stage is single-entry: one request per two cycles at best.
- Tracker: FIFO, depth NUM_OUTSTANDING.
  - Full: gnt_o = 0.
  - Push and pop in the same cycle allowed; count unchanged.
- D channel:
  - Every d_valid_i beat is consumed.
  - If d_source_i ≠ tracker head source, or the tracker is empty: err_o is set (sticky), nothing pops, rvalid_o is not pulsed.
  - On match: pop the head.
    - Head is a read with opcode AccessAckData: rvalid_o = 1 the next cycle, rdata_o = d_data_i registered.
    - Head is a write: completes silently, no rvalid.
    - Opcode inconsistent with head type (e.g. AccessAck for a read): err_o set, entry still popped.
- idle_o = !a_hold && tracker empty.
- Reset mid-transaction: all state cleared; late D beats then hit the empty tracker and set err_o.
- A gnt and a D pop in the same cycle are both honoured.

Optional Feature:
- CPU64_TL_BRIDGE_DERR_EN
  - Defined: a matching D beat with d_denied_i or d_corrupt_i = 1 sets err_o. For a read it still pulses rvalid_o, with rdata_o forced to 64'h0.
  - Undefined: d_denied_i and d_corrupt_i are ignored; err_o reports only source/opcode mismatches.

Decomposition:
- Package cpu64_tl_pkg:
  - TL opcode constants: TL_GET, TL_PUT_FULL, TL_PUT_PARTIAL, TL_ACCESS_ACK, TL_ACCESS_ACK_DATA.
  - TL_SIZE_8B = 3.
  - Tracker entry typedef {source, is_read}.
- Sub-module cpu64_tl_src_fifo: parameterised synchronous FIFO for the in-order tracker, with push/pop/full/empty/head.

Test Plan:
- Read 0x1000; slave returns AccessAckData, source 0, data 0x1122334455667788 → a_opcode 4, a_mask FF, a_size 3; rvalid_o pulses once with rdata 0x1122334455667788; idle_o returns to 1.
- Write 0x2008, be F0, data BEEF_BEEF_0000_0000 → a_opcode 1, a_mask F0, data passed through; AccessAck produces no rvalid; err_o stays 0.
- Write be FF → a_opcode 0.
- Slave holds a_ready_i = 0 for 5 cycles → a_valid_o and payload stable throughout; gnt_o = 0 throughout; fire on the 6th cycle.
- Four reads issued with D withheld → sources 0,1,2,3; 5th req sees gnt_o = 0 until the first D beat pops; in-order responses yield four rvalid pulses in order.
- D beat with source 2 while head is 0 → err_o = 1 and stays 1; no rvalid.
- With CPU64_TL_BRIDGE_DERR_EN, read answered with d_denied_i = 1 → rvalid_o with rdata 0; err_o = 1.

Source files
------------

// File: rtl/cpu64_tl_pkg.sv
// TileLink-UL constants and tracker entry type shared by the L1 memory-side bridge.
package cpu64_tl_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam logic [2:0] TL_SIZE_8B = 3'd3;

  // Tracker source field is sized for the widest supported tag; narrower tags zero-extend.
  localparam int unsigned TL_SRC_W_MAX = 8;

  typedef struct packed {
    logic [TL_SRC_W_MAX-1:0] source;
    logic                    is_read;
  } trk_entry_t;

  function automatic logic [2:0] a_opcode_for(input logic we, input logic [7:0] be);
    if (!we) return TL_GET;
    if (be == 8'hFF) return TL_PUT_FULL;
    return TL_PUT_PARTIAL;
  endfunction

endpackage

// File: rtl/cpu64_tl_src_fifo.sv
// Synchronous in-order FIFO used to track outstanding TL transactions; DEPTH must be a power of two.
module cpu64_tl_src_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu64_l1_tl_ul_bridge.sv
// L1 dcache memory port to TileLink-UL master bridge with in-order response tracking.
// Optional: define CPU64_TL_BRIDGE_DERR_EN to flag d_denied/d_corrupt and zero denied read data.
module cpu64_l1_tl_ul_bridge
  import cpu64_tl_pkg::*;
#(
  parameter int unsigned AW              = 64,
  parameter int unsigned NUM_OUTSTANDING = 4,
  parameter int unsigned SRC_W           = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [7:0]       be_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [63:0]      wdata_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [63:0]      rdata_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [2:0]       a_opcode_o,
  output logic [2:0]       a_size_o,
  output logic [SRC_W-1:0] a_source_o,
  output logic [AW-1:0]    a_address_o,
  output logic [7:0]       a_mask_o,
  output logic [63:0]      a_data_o,
  input  logic             d_valid_i,
  output logic             d_ready_o,
  input  logic [2:0]       d_opcode_i,
  input  logic [SRC_W-1:0] d_source_i,
  input  logic             d_denied_i,
  input  logic             d_corrupt_i,
  input  logic [63:0]      d_data_i,
  output logic             err_o,
  output logic             idle_o
);

  localparam int unsigned ENTRY_W = $bits(trk_entry_t);

  typedef enum logic {A_IDLE, A_HOLD} a_state_e;

  a_state_e   a_state_q, a_state_d;
  logic       a_hold;
  logic       a_load_c;

  logic [SRC_W-1:0] src_cnt;
  trk_entry_t       push_entry;
  trk_entry_t       trk_head;
  logic             trk_full;
  logic             trk_empty;

  logic       src_match_c;
  logic       op_ok_c;
  logic       derr_c;
  logic       d_pop_c;
  logic       rd_done_c;
  logic       err_set_c;
  logic       rvalid_q;
  logic [63:0] rdata_q;
  logic       err_q;

  assign a_hold    = (a_state_q == A_HOLD);
  assign gnt_o     = req_i && !a_hold && !trk_full;
  assign a_valid_o = a_hold;
  assign d_ready_o = 1'b1;
  assign idle_o    = !a_hold && trk_empty;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

  // A-stage state register.
  always_ff @(posedge clk) begin
    if (!rst_n) a_state_q <= A_IDLE;
    else        a_state_q <= a_state_d;
  end

  // A-stage next state: load on grant, release on handshake.
  always_comb begin
    a_state_d = a_state_q;
    a_load_c  = 1'b0;
    case (a_state_q)
      A_IDLE: begin
        if (gnt_o) begin
          a_load_c  = 1'b1;
          a_state_d = A_HOLD;
        end
      end
      A_HOLD: begin
        if (a_ready_i) a_state_d = A_IDLE;
      end
      default: a_state_d = A_IDLE;
    endcase
  end

  // A holding register; payload stays put until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_opcode_o  <= '0;
      a_size_o    <= '0;
      a_source_o  <= '0;
      a_address_o <= '0;
      a_mask_o    <= '0;
      a_data_o    <= '0;
      src_cnt     <= '0;
    end else if (a_load_c) begin
      a_opcode_o  <= a_opcode_for(we_i, be_i);
      a_size_o    <= TL_SIZE_8B;
      a_source_o  <= src_cnt;
      a_address_o <= addr_i;
      a_mask_o    <= we_i ? be_i : 8'hFF;
      a_data_o    <= wdata_i;
      src_cnt     <= src_cnt + SRC_W'(1);
    end
  end

  assign push_entry.source  = TL_SRC_W_MAX'(src_cnt);
  assign push_entry.is_read = !we_i;

  cpu64_tl_src_fifo #(
    .DEPTH (NUM_OUTSTANDING),
    .W     (ENTRY_W)
  ) u_trk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (a_load_c),
    .din   (push_entry),
    .pop   (d_pop_c),
    .head  (trk_head),
    .full  (trk_full),
    .empty (trk_empty)
  );

`ifdef CPU64_TL_BRIDGE_DERR_EN
  assign derr_c = d_denied_i || d_corrupt_i;
`else
  logic unused_derr;
  assign unused_derr = d_denied_i ^ d_corrupt_i;
  assign derr_c      = 1'b0;
`endif

  // D-channel decode: beats must match the oldest outstanding source.
  always_comb begin
    src_match_c = !trk_empty && (trk_head.source == TL_SRC_W_MAX'(d_source_i));
    op_ok_c     = d_opcode_i == (trk_head.is_read ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK);
    d_pop_c     = d_valid_i && src_match_c;
    rd_done_c   = d_pop_c && trk_head.is_read && op_ok_c;
    err_set_c   = d_valid_i && (!src_match_c || !op_ok_c || derr_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_done_c;
      if (rd_done_c) rdata_q <= derr_c ? 64'h0 : d_data_i;
      if (err_set_c) err_q <= 1'b1;
    end
  end

endmodule
